// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Purpose : Shared Wishbone definitions: FSM state encoding, default bus
//           widths, response status struct and the timeout counter width
//           helper. Imported by the master controller and slave blocks.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int unsigned WB_AW = 8;
  localparam int unsigned WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Status bits carried alongside read data on the response channel.
  typedef struct packed {
    logic err;  // slave error or timeout
    logic to;   // timeout only
  } wb_rsp_status_t;

  // Counter wide enough to hold the limit, clamped to 8..32 bits.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_master_ctrl_if
// Purpose : Groups the command stream, response stream and Wishbone classic
//           signals of the single-transfer initiator.
// Ports   : none; modport master is the controller view, modport slave is
//           the view of the command source / bus slave (testbench side).
// Revision: 1.0 - initial release
// ============================================================================
interface wb_master_ctrl_if
  import wb_pkg::*;
#(
  parameter int unsigned AW = WB_AW,
  parameter int unsigned DW = WB_DW
) ();

  // command channel
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i;
  // response channel
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic          rsp_to_o;
  // Wishbone
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;
  logic          err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
           dat_i, ack_i, err_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_to_o,
           cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
           dat_i, ack_i, err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, rsp_to_o,
           cyc_o, stb_o, we_o, adr_o, dat_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module  : wb_timeout_cnt
// Purpose : Bus-cycle watchdog. Cleared when a transfer starts, counts each
//           wait cycle and flags the cycle whose count would reach LIMIT.
// Ports   : clk_i     - clock
//           rst_i     - asynchronous active-low reset
//           clr_i     - restart count (transfer accepted)
//           en_i      - count this cycle (in BUS, no ack/err)
//           expired_o - this counting cycle reaches LIMIT
// Revision: 1.0 - initial release
// ============================================================================
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      expired_o
);

  localparam int unsigned CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Flag one cycle early so the FSM leaves BUS exactly at the LIMIT-th edge.
  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/wb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wb_master_ctrl
// Purpose : Single-transfer Wishbone classic initiator. Accepts one command,
//           runs one bus cycle, returns data/status on the response channel.
//           Optional bus timeout enabled by macro WB_MASTER_TIMEOUT_EN.
// Ports   : clk_i  - clock
//           rst_i  - asynchronous active-low reset
//           bus    - wb_master_ctrl_if.master: cmd_*, rsp_*, Wishbone
//                    cyc/stb/we/adr/dat_o/dat_i/ack/err
// Revision: 1.0 - initial release
// ============================================================================
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned AW        = WB_AW,
  parameter int unsigned DW        = WB_DW,
  parameter int unsigned TO_CYCLES = 255
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  wb_master_ctrl_if.master  bus
);

  if (TO_CYCLES < 1) begin : g_to_cycles_check
    $error("wb_master_ctrl: TO_CYCLES must be >= 1");
  end

  wb_state_e      state_q;
  logic           cyc_q;
  logic           we_q;
  logic [AW-1:0]  adr_q;
  logic [DW-1:0]  dat_q;
  logic           rsp_valid_q;
  logic [DW-1:0]  rsp_data_q;
  wb_rsp_status_t rsp_stat_q;

  logic accept;
  logic bus_done;
  logic to_expired;

  // Ready is a decode of IDLE gated by reset so it is low throughout reset.
  assign accept   = bus.cmd_valid_i && bus.cmd_ready_o;
  assign bus_done = bus.ack_i || bus.err_i;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_cnt #(
    .LIMIT (TO_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (accept),
    .en_i      ((state_q == BUS) && !bus_done),
    .expired_o (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_stat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.cmd_we_i;
            adr_q   <= bus.cmd_addr_i;
            dat_q   <= bus.cmd_data_i;
            cyc_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (bus_done) begin
            // err wins over ack; only a clean read ack returns data.
            rsp_data_q     <= (!we_q && bus.ack_i && !bus.err_i) ? bus.dat_i : '0;
            rsp_stat_q.err <= bus.err_i;
            rsp_stat_q.to  <= 1'b0;
            rsp_valid_q    <= 1'b1;
            cyc_q          <= 1'b0;
            state_q        <= RESP;
          end else if (to_expired) begin
            rsp_data_q     <= '0;
            rsp_stat_q.err <= 1'b1;
            rsp_stat_q.to  <= 1'b1;
            rsp_valid_q    <= 1'b1;
            cyc_q          <= 1'b0;
            state_q        <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = rst_i && (state_q == IDLE);
  assign bus.cyc_o       = cyc_q;
  assign bus.stb_o       = cyc_q;
  assign bus.we_o        = we_q;
  assign bus.adr_o       = adr_q;
  assign bus.dat_o       = dat_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_stat_q.err;
  assign bus.rsp_to_o    = rsp_stat_q.to;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_master_ctrl
// Purpose : Self-checking bench for wb_master_ctrl. Expected responses are
//           queued when each command is driven and compared on response.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_master_ctrl;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic clk;
  logic rst_n;

  wb_master_ctrl_if #(.AW(8), .DW(32)) bus ();

  wb_master_ctrl #(
    .AW        (8),
    .DW        (32),
    .TO_CYCLES (TO_CYC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for ready, drive one command, queue its predicted response.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic ack, input logic err,
                       input logic to);
    int   w;
    exp_t e;
    w = 0;
    while (bus.cmd_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready_o}, 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = wdata;
    e.to   = to;
    e.err  = err | to;
    e.data = (!to && !we && ack && !err) ? rdata : 32'd0;
    sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("cmd_ready_busy", {31'd0, bus.cmd_ready_o}, 32'd0);
  endtask

  // Called in the first BUS cycle; slave answers after `waits` wait cycles.
  task automatic bus_wait(input int waits, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic ack, input logic err);
    int n;
    n = 0;
    bus.dat_i = rdata;
    forever begin
      chk("cyc_stb", {30'd0, bus.cyc_o, bus.stb_o}, 32'd3);
      chk("we_hold", {31'd0, bus.we_o}, {31'd0, we});
      chk("adr_hold", {24'd0, bus.adr_o}, {24'd0, addr});
      chk("dat_hold", bus.dat_o, wdata);
      if (n == waits) begin
        bus.ack_i = ack;
        bus.err_i = err;
      end
      @(negedge clk);
      n++;
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      if (bus.cyc_o !== 1'b1 || n >= 300) break;
    end
    chk("bus_cycles", n, waits + 1);
  endtask

  task automatic take_rsp();
    exp_t e;
    chk("rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
    chk("cyc_resp", {31'd0, bus.cyc_o}, 32'd0);
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_underflow observed=%0d expected=>0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_data", bus.rsp_data_o, e.data);
      chk("rsp_err", {31'd0, bus.rsp_err_o}, {31'd0, e.err});
      chk("rsp_to", {31'd0, bus.rsp_to_o}, {31'd0, e.to});
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("rsp_valid_clr", {31'd0, bus.rsp_valid_o}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_data;
    logic        hold_err;
    int          n;

    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.dat_i       = '0;
    bus.ack_i       = 1'b0;
    bus.err_i       = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    chk("rst_cyc", {30'd0, bus.cyc_o, bus.stb_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("rst_adr", {24'd0, bus.adr_o}, 32'd0);
    chk("rst_dat", bus.dat_o, 32'd0);
    chk("rst_rsp_data", bus.rsp_data_o, 32'd0);
    chk("rst_rsp_flags", {30'd0, bus.rsp_err_o, bus.rsp_to_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.cmd_ready_o}, 32'd1);

    // stray ack/err outside BUS is ignored
    bus.ack_i = 1'b1;
    bus.err_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    chk("stray_ack_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("stray_ack_cyc", {31'd0, bus.cyc_o}, 32'd0);

    // write with two wait states
    issue(1'b1, 8'h04, 32'hDEADBEEF, 32'hFFFF0000, 1'b1, 1'b0, 1'b0);
    bus_wait(2, 1'b1, 8'h04, 32'hDEADBEEF, 32'hFFFF0000, 1'b1, 1'b0);
    take_rsp();

    // zero-wait read
    issue(1'b0, 8'h08, 32'h0, 32'h0000A5A5, 1'b1, 1'b0, 1'b0);
    bus_wait(0, 1'b0, 8'h08, 32'h0, 32'h0000A5A5, 1'b1, 1'b0);
    take_rsp();

    // ack and err together: err wins, data zero
    issue(1'b0, 8'h0C, 32'h0, 32'h00001234, 1'b1, 1'b1, 1'b0);
    bus_wait(1, 1'b0, 8'h0C, 32'h0, 32'h00001234, 1'b1, 1'b1);
    take_rsp();

    // write error only
    issue(1'b1, 8'hFF, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b1, 1'b0);
    bus_wait(0, 1'b1, 8'hFF, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b1);
    take_rsp();

    // backpressure: response held while a new command waits
    issue(1'b0, 8'h20, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    bus_wait(1, 1'b0, 8'h20, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
    hold_data = bus.rsp_data_o;
    hold_err  = bus.rsp_err_o;
    chk("bp_data_first", hold_data, 32'hCAFEF00D);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_addr_i  = 8'h10;
    bus.cmd_data_i  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
      chk("bp_rsp_data", bus.rsp_data_o, 32'hCAFEF00D);
      chk("bp_rsp_err", {31'd0, bus.rsp_err_o}, {31'd0, hold_err});
      @(negedge clk);
    end
    begin
      exp_t e;
      e = sb.pop_front();
      chk("bp_pop_data", bus.rsp_data_o, e.data);
      e.data = 32'h00000077;
      e.err  = 1'b0;
      e.to   = 1'b0;
      sb.push_back(e);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("bp_rsp_clr", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("bp_next_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("bp_next_accepted", {31'd0, bus.cyc_o}, 32'd1);
    bus_wait(0, 1'b0, 8'h10, 32'h0, 32'h00000077, 1'b1, 1'b0);
    take_rsp();

    // reset in the middle of a bus cycle
    issue(1'b0, 8'h30, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("mid_cyc_before", {31'd0, bus.cyc_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {30'd0, bus.cyc_o, bus.stb_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    chk("post_rst_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    issue(1'b0, 8'h34, 32'h0, 32'h13579BDF, 1'b1, 1'b0, 1'b0);
    bus_wait(3, 1'b0, 8'h34, 32'h0, 32'h13579BDF, 1'b1, 1'b0);
    take_rsp();

`ifdef WB_MASTER_TIMEOUT_EN
    // no answer: transfer aborts after TO_CYC bus cycles
    issue(1'b0, 8'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (bus.cyc_o === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to_bus_cycles", n, TO_CYC);
    take_rsp();

    // ack on the limit cycle beats the timeout
    issue(1'b0, 8'h44, 32'h0, 32'h00C0FFEE, 1'b1, 1'b0, 1'b0);
    bus_wait(TO_CYC - 1, 1'b0, 8'h44, 32'h0, 32'h00C0FFEE, 1'b1, 1'b0);
    take_rsp();
`else
    // no answer: bus waits indefinitely
    issue(1'b0, 8'h40, 32'h0, 32'h00000042, 1'b1, 1'b0, 1'b0);
    n = 0;
    repeat (110) begin
      if (bus.cyc_o === 1'b1) n++;
      @(negedge clk);
    end
    chk("no_to_cyc_held", n, 110);
    chk("no_to_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    bus_wait(0, 1'b0, 8'h40, 32'h0, 32'h00000042, 1'b1, 1'b0);
    take_rsp();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_master_ctrl.md
Name: wb_master_ctrl

Overview:
Single-transfer Wishbone classic initiator. Turns a valid/ready command stream from a CPU-side or test controller into Wishbone read/write cycles, and returns read data and status on a response channel. It is the master end that drives slave peripherals such as the GPIO block on the shared bus.

Parameters:
AW, 8, address width (byte address, passed through unchanged)
DW, 32, data width
TO_CYCLES, 255, cycles without ack/err before abort (used only with the optional feature); must be >= 1

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o at a rising edge
cmd_we_i  in  1  1 = write, 0 = read
cmd_addr_i  in  AW  target address
cmd_data_i  in  DW  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i at a rising edge
rsp_data_o  out  DW  read data; 0 for writes and errors
rsp_err_o  out  1  slave err_i, or timeout
rsp_to_o  out  1  timeout flag; tied 0 without the optional feature
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  AW  Wishbone address
dat_o  out  DW  Wishbone write data
dat_i  in  DW  Wishbone read data
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone error

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, rsp_to_o = 0; adr_o, dat_o, rsp_data_o = 0; cmd_ready_o = 0 while rst_i is low. Reset during a bus cycle drops cyc_o/stb_o immediately and discards the transfer. No response is produced for it.
- FSM states: IDLE, BUS, RESP.
- IDLE: cmd_ready_o = 1. On accept, register we/addr/data into we_o/adr_o/dat_o, go to BUS. cyc_o and stb_o rise in the cycle after the accept edge.
- BUS: cyc_o = stb_o = 1; we_o, adr_o and dat_o are held stable; cmd_ready_o = 0. At any edge with ack_i or err_i high:
  - capture rsp_data_o = dat_i when the transfer is a read with ack and no err; otherwise capture 0;
  - rsp_err_o = err_i;
  - drop cyc_o/stb_o in the next cycle;
  - go to RESP.
  Both ack_i and err_i high in the same cycle: err takes priority, rsp_err_o = 1, data 0. A slave that acks in the first BUS cycle is legal, giving minimum bus occupancy of 1 cycle.
- RESP: rsp_valid_o = 1 and the response fields are held until the rsp_ready_i handshake, then go to IDLE. cmd_ready_o = 0 in RESP, so at most one outstanding transfer exists. ack_i/err_i arriving outside BUS are ignored.
- Throughput: accept -> BUS (>= 1 cycle) -> RESP (>= 1 cycle) -> IDLE. Best case is one command per 3 cycles.
- Widths: all fields pass through unchanged; no byte-select generation; sel is implicitly all-ones.

Optional Feature:
WB_MASTER_TIMEOUT_EN
- Defined:
  - an 8..32-bit counter, sized by $clog2(TO_CYCLES+1), clears on entry to BUS and increments each BUS cycle without ack_i/err_i;
  - when it reaches TO_CYCLES, the FSM drops cyc_o/stb_o, enters RESP with rsp_err_o = 1, rsp_to_o = 1, rsp_data_o = 0;
  - ack_i in the same cycle the limit is reached wins over the timeout.
- Not defined: no counter; BUS waits indefinitely; rsp_to_o constant 0.

Decomposition:
- Shared package wb_pkg:
  - FSM state enum: IDLE, BUS, RESP, 2-bit encoding;
  - default AW/DW constants;
  - response struct or field constants, shared with the slave blocks.
- One natural sub-module, wb_timeout_cnt: the timeout counter with clear/enable/expired, instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Write: cmd we=1, addr 0x04, data 0xDEADBEEF; slave acks after 2 wait cycles -> adr_o=0x04, dat_o=0xDEADBEEF, we_o=1 stable for 3 cycles; rsp_valid_o with rsp_err_o=0, rsp_data_o=0.
- Read with zero wait: cmd we=0, addr 0x08; ack_i in the first BUS cycle with dat_i=0x0000A5A5 -> rsp_data_o=0x0000A5A5; cyc_o high exactly 1 cycle.
- Error and priority: ack_i and err_i high together on a read with dat_i=0x1234 -> rsp_err_o=1, rsp_data_o=0.
- Backpressure: rsp_ready_i held low 5 cycles with cmd_valid_i high -> cmd_ready_o=0 and the response is stable throughout; the next command is accepted the cycle after the rsp handshake.
- Reset mid-cycle: rst_i low while in BUS -> cyc_o/stb_o low in the same cycle (async); after release the FSM is in IDLE, rsp_valid_o=0, and a new read completes normally.
- Timeout (macro defined, TO_CYCLES=4): no ack_i -> cyc_o drops after 4 BUS cycles; rsp_err_o=1, rsp_to_o=1. Without the macro, cyc_o stays high for 100+ cycles.
